// File: rtl/alt_lut_pkg.sv
// Shared types for the run-time loadable LUT6 bank: mask/address widths and config FSM states.
package alt_lut_pkg;

  localparam int LUT_MASK_W = 64;
  localparam int LUT_ADDR_W = 6;

  typedef logic [LUT_MASK_W-1:0] lut_mask_t;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_LOAD,
    CFG_COMMIT
  } cfg_state_e;

endpackage

// File: rtl/alt_lut6_cell.sv
// One LUT6 channel: write-enabled mask register plus a registered 64:1 lookup.
// ALT_LUT_READBACK_EN exposes the live mask for the bank's readback mux.
module alt_lut6_cell
  import alt_lut_pkg::*;
#(
  parameter lut_mask_t INIT_MASK = 64'h8000_0000_0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  lut_mask_t             wdata,
  input  logic                  lookup_en,
  input  logic [LUT_ADDR_W-1:0] addr,
`ifdef ALT_LUT_READBACK_EN
  output lut_mask_t             mask,
`endif
  output logic                  q
);

  lut_mask_t mask_q;

  // The lookup reads mask_q before a same-edge write lands, so a lookup in the
  // commit cycle sees the old mask.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= INIT_MASK;
      q      <= 1'b0;
    end else begin
      if (we)
        mask_q <= wdata;
      if (lookup_en)
        q <= mask_q[addr];
    end
  end

`ifdef ALT_LUT_READBACK_EN
  assign mask = mask_q;
`endif

endmodule

// File: rtl/alt_lut6_cfg_bank.sv
// Bank of NUM_LUTS run-time loadable LUT6 channels with beat-serial atomic mask load.
// ALT_LUT_READBACK_EN adds rb_sel/rb_mask registered mask readback.
module alt_lut6_cfg_bank
  import alt_lut_pkg::*;
#(
  parameter int        NUM_LUTS  = 8,
  parameter int        CFG_W     = 16,
  parameter lut_mask_t INIT_MASK = 64'h8000_0000_0000_0000,
  parameter int        OUT_REG   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [NUM_LUTS*6-1:0]         din,
  output logic                          out_valid,
  output logic [NUM_LUTS-1:0]           dout,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_LUTS):0]     cfg_sel,
  input  logic [CFG_W-1:0]              cfg_data,
  output logic                          cfg_done,
`ifdef ALT_LUT_READBACK_EN
  input  logic [$clog2(NUM_LUTS):0]     rb_sel,
  output lut_mask_t                     rb_mask,
`endif
  output logic                          cfg_err
);

  localparam int BEATS = LUT_MASK_W / CFG_W;
  localparam int SEL_W = $clog2(NUM_LUTS) + 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((LUT_MASK_W % CFG_W) != 0 || CFG_W < 8 || CFG_W > 64) begin : g_bad_cfg_w
    $error("alt_lut6_cfg_bank: CFG_W must divide 64 (8,16,32,64)");
  end
  if (NUM_LUTS < 1 || NUM_LUTS > 64) begin : g_bad_num
    $error("alt_lut6_cfg_bank: NUM_LUTS must be 1..64");
  end

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return s < SEL_W'(NUM_LUTS);
  endfunction

  cfg_state_e                     state;
  logic [CNT_W-1:0]               cnt;
  logic [SEL_W-1:0]               sel_r;
  logic [BEATS-1:0][CFG_W-1:0]    shadow;
  logic                           accept;

  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CFG_IDLE;
      cnt       <= '0;
      sel_r     <= '0;
      shadow    <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        CFG_IDLE: begin
          cfg_ready <= 1'b1;
          if (accept) begin
            sel_r     <= cfg_sel;
            shadow[0] <= cfg_data;
            if (BEATS == 1) begin
              state     <= CFG_COMMIT;
              cfg_ready <= 1'b0;
              cfg_done  <= sel_ok(cfg_sel);
              cfg_err   <= !sel_ok(cfg_sel);
            end else begin
              state <= CFG_LOAD;
              cnt   <= CNT_W'(1);
            end
          end
        end
        CFG_LOAD: begin
          if (accept) begin
            shadow[cnt] <= cfg_data;
            cnt         <= cnt + 1'b1;
            if (cnt == CNT_W'(BEATS - 1)) begin
              state     <= CFG_COMMIT;
              cfg_ready <= 1'b0;
              cfg_done  <= sel_ok(sel_r);
              cfg_err   <= !sel_ok(sel_r);
            end
          end
        end
        default: begin
          state     <= CFG_IDLE;
          cnt       <= '0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // p0: channel lookups registered inside the cells
  logic                vld_p0;
  logic [NUM_LUTS-1:0] lut_p0;
  lut_mask_t           commit_mask;
  logic                commit;

  assign commit_mask = shadow;
  assign commit      = (state == CFG_COMMIT);

`ifdef ALT_LUT_READBACK_EN
  lut_mask_t masks [NUM_LUTS];
`endif

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_cell
    alt_lut6_cell #(.INIT_MASK(INIT_MASK)) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (commit && (sel_r == SEL_W'(i))),
      .wdata     (commit_mask),
      .lookup_en (in_valid),
      .addr      (din[6*i +: 6]),
`ifdef ALT_LUT_READBACK_EN
      .mask      (masks[i]),
`endif
      .q         (lut_p0[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= in_valid;
  end

  // p1: optional output register
  if (OUT_REG != 0) begin : g_oreg
    logic                vld_p1;
    logic [NUM_LUTS-1:0] lut_p1;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p1 <= 1'b0;
        lut_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0)
          lut_p1 <= lut_p0;
      end
    end
    assign out_valid = vld_p1;
    assign dout      = lut_p1;
  end else begin : g_nooreg
    assign out_valid = vld_p0;
    assign dout      = lut_p0;
  end

`ifdef ALT_LUT_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_mask <= '0;
    end else begin
      rb_mask <= '0;
      for (int i = 0; i < NUM_LUTS; i++)
        if (rb_sel == SEL_W'(i))
          rb_mask <= masks[i];
    end
  end
`endif

endmodule
